// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) doubling, FSM states, block width
// and the round count derived from the key length.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns
// (bypassed when last is set) and AddRoundKey. Byte 0 sits in [127:120].
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state,
  input  logic [AES_BLOCK_W-1:0] key,
  input  logic                   last,
  output logic [AES_BLOCK_W-1:0] result
);

  function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte index is 4*column + row; row r rotates left by r columns.
  function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul2(a0) ^ gf_mul2(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gf_mul2(a1) ^ gf_mul2(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul2(a3) ^ a3;
      o[103-32*c -: 8] = gf_mul2(a0) ^ a0 ^ a1 ^ a2 ^ gf_mul2(a3);
    end
    return o;
  endfunction

  logic [AES_BLOCK_W-1:0] shifted;

  assign shifted = shift_rows(sub_bytes(state));
  assign result  = (last ? shifted : mix_columns(shifted)) ^ key;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock over a single state
// register. Define AES_CIPHER_BLK_CNT_EN to add the blk_cnt handshake counter.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter  int Nk = 4,
  localparam int Nr = nr_from_nk(Nk)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [AES_BLOCK_W-1:0]         plain_text,
  input  logic [AES_BLOCK_W*(Nr+1)-1:0]  round_keys,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [AES_BLOCK_W-1:0]         cipher_text,
  output logic                           busy
`ifdef AES_CIPHER_BLK_CNT_EN
  ,
  output logic [31:0]                    blk_cnt
`endif
);

  if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
    $error("aes_cipher_iter: Nk must be 4, 6 or 8");
  end

  aes_state_e             fsm;
  logic [AES_BLOCK_W-1:0] state_q;
  logic [AES_BLOCK_W-1:0] key_q [Nr+1];
  logic [3:0]             rnd;
  logic                   last;
  logic [AES_BLOCK_W-1:0] round_out;

  assign last = (rnd == 4'(Nr));

  aes_round_comb u_round (
    .state  (state_q),
    .key    (key_q[rnd]),
    .last   (last),
    .result (round_out)
  );

  // Output is forced to zero whenever no result is being offered.
  assign cipher_text = out_valid ? state_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_q   <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int r = 0; r <= Nr; r++) key_q[r] <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= plain_text ^ round_keys[0 +: AES_BLOCK_W];
            for (int r = 0; r <= Nr; r++) key_q[r] <= round_keys[AES_BLOCK_W*r +: AES_BLOCK_W];
            rnd      <= 4'd1;
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (last) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef AES_CIPHER_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) blk_cnt <= '0;
    else if (out_valid && out_ready) blk_cnt <= blk_cnt + 32'd1;
  end
`endif

endmodule
